// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block.
//   state_t      : FSM states (ST_IDLE, ST_PULSE, ST_SCAN)
//   MODE_SINGLE  : req_mode value selecting a single one-hot pulse
//   MODE_SCAN    : req_mode value selecting an upward sweep
//   addr_width() : index width for a given output count, never below 1
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Request/response bundle between a requester and scan_decoder.
//   enable     : requester -> decoder, gates output and stalls sequences
//   req_valid  : requester -> decoder, request present
//   req_mode   : requester -> decoder, MODE_SINGLE or MODE_SCAN
//   req_addr   : requester -> decoder, target / start index
//   err_clr    : requester -> decoder, clears the sticky error flag
//   req_ready  : decoder -> requester, request can be accepted
//   out        : decoder -> requester, registered one-hot outputs
//   busy       : decoder -> requester, a sequence is in progress
//   done       : decoder -> requester, final active cycle marker
//   err        : decoder -> requester, sticky out-of-range flag
interface scan_decoder_if #(
    parameter int NUM_OUT = 4
);
    import scan_decoder_pkg::*;

    localparam int ADDR_W = addr_width(NUM_OUT);

    logic               enable;
    logic               req_valid;
    logic               req_mode;
    logic [ADDR_W-1:0]  req_addr;
    logic               err_clr;
    logic               req_ready;
    logic [NUM_OUT-1:0] out;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output enable, req_valid, req_mode, req_addr, err_clr,
        input  req_ready, out, busy, done, err
    );

    modport slave (
        input  enable, req_valid, req_mode, req_addr, err_clr,
        output req_ready, out, busy, done, err
    );

endinterface

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational index to one-hot decoder.
//   idx      : in  index to decode
//   onehot   : out single set bit at position idx, all zero when out of range
//   in_range : out high when idx < NUM_OUT
module onehot_decode
    import scan_decoder_pkg::*;
#(
    parameter  int NUM_OUT = 4,
    localparam int ADDR_W  = addr_width(NUM_OUT)
) (
    input  logic [ADDR_W-1:0]  idx,
    output logic [NUM_OUT-1:0] onehot,
    output logic               in_range
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (idx == ADDR_W'(i));
        end
    end

    // Extra MSB so NUM_OUT itself is representable when it is a power of two.
    assign in_range = ({1'b0, idx} < (ADDR_W + 1)'(NUM_OUT));

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a request handshake.
// Single mode holds 1<<addr for PULSE_LEN enabled cycles; scan mode sweeps
// from the requested index up to NUM_OUT-1, one index per enabled cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : scan_decoder_if slave (handshake, enable, outputs, error flag)
// Configuration macro SCAN_DECODER_RANGE_CHECK_EN:
//   defined   - an accepted out-of-range address is rejected: the block stays
//               idle and raises done plus the sticky err one cycle later.
//   undefined - no check; such a request runs with all-zero outputs and err
//               is tied low.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int NUM_OUT   = 4,
    parameter int PULSE_LEN = 1
) (
    input logic          clk,
    input logic          reset,
    scan_decoder_if.slave bus
);

    localparam int                ADDR_W   = addr_width(NUM_OUT);
    localparam int                CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_OUT - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  idx;
    logic [NUM_OUT-1:0] out_q;
    logic               done_q;
    logic               err_q;
    logic               err_pend;
    logic               req_ready_i;
    logic               accept;
    logic               start_ok;
    logic [ADDR_W-1:0]  dec_idx;
    logic [NUM_OUT-1:0] dec;
    logic               in_range;

    // While idle the decoder looks at the incoming address so its range flag
    // can qualify the request; once running it decodes the held index.
    assign dec_idx = (state == ST_IDLE) ? bus.req_addr : idx;

    onehot_decode #(.NUM_OUT(NUM_OUT)) u_decode (
        .idx      (dec_idx),
        .onehot   (dec),
        .in_range (in_range)
    );

    assign accept = bus.req_valid && req_ready_i;

`ifdef SCAN_DECODER_RANGE_CHECK_EN
    assign start_ok    = in_range;
    // Ready drops while a rejection is pending so the held request is not
    // accepted a second time before done/err are reported.
    assign req_ready_i = (state == ST_IDLE) && !err_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_pend <= accept && !in_range;
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end else if (err_pend) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign start_ok    = 1'b1;
    assign req_ready_i = (state == ST_IDLE);
    assign err_pend    = 1'b0;
    assign err_q       = 1'b0;
    assign unused_cfg  = in_range ^ bus.err_clr;
`endif

    // The done cycle still belongs to PULSE/SCAN, so busy stays high and
    // ready returns only on the cycle after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            idx    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_q  <= '0;
                    done_q <= err_pend;
                    count  <= '0;
                    if (accept && start_ok) begin
                        idx   <= bus.req_addr;
                        state <= (bus.req_mode == MODE_SCAN) ? ST_SCAN : ST_PULSE;
                    end
                end
                ST_PULSE, ST_SCAN: begin
                    if (done_q) begin
                        state  <= ST_IDLE;
                        out_q  <= '0;
                        done_q <= 1'b0;
                    end else if (bus.enable) begin
                        out_q <= dec;
                        if (state == ST_PULSE) begin
                            count  <= count + CNT_W'(1);
                            done_q <= (count == CNT_LAST);
                        end else begin
                            // >= also ends a length-1 scan of an out-of-range start.
                            done_q <= (idx >= IDX_LAST);
                            if (idx < IDX_LAST) begin
                                idx <= idx + ADDR_W'(1);
                            end
                        end
                    end else begin
                        out_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_i;
    assign bus.out       = out_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
